// File: rtl/rr_onehot_arbiter_pkg.sv
// Shared defaults for the L1D round-robin request arbiter.
// Imported by the arbiter top and its payload mux.
package rr_onehot_arbiter_pkg;

  localparam int DEF_SOURCE_COUNT = 4;
  localparam int DEF_DATA_WIDTH   = 32;

endpackage

// File: rtl/rr_onehot_arbiter_onehot_mux.sv
// One-hot select mux: ORs together the payloads whose select bit is set.
// With a one-hot or all-zero select this is a plain N-to-1 mux.
module onehot_mux
  import rr_onehot_arbiter_pkg::*;
#(
  parameter int SOURCE_COUNT = DEF_SOURCE_COUNT,
  parameter int DATA_WIDTH   = DEF_DATA_WIDTH
) (
  input  logic [SOURCE_COUNT-1:0]            sel_i,
  input  logic [SOURCE_COUNT*DATA_WIDTH-1:0] data_i,
  output logic [DATA_WIDTH-1:0]              data_o
);

  always_comb begin
    data_o = '0;
    for (int j = 0; j < SOURCE_COUNT; j++) begin
      if (sel_i[j]) begin
        data_o = data_o | data_i[j*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

endmodule

// File: rtl/rr_onehot_arbiter.sv
// Round-robin N-to-1 arbiter feeding a single registered output slot.
// Grant is one-hot; slot reports payload, one-hot and binary source.
module rr_onehot_arbiter
  import rr_onehot_arbiter_pkg::*;
#(
  parameter int SOURCE_COUNT = DEF_SOURCE_COUNT,
  parameter int DATA_WIDTH   = DEF_DATA_WIDTH
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic [SOURCE_COUNT-1:0]            req_valid_i,
  input  logic [SOURCE_COUNT*DATA_WIDTH-1:0] req_data_i,
  output logic [SOURCE_COUNT-1:0]            req_ready_o,
  output logic                               out_valid_o,
  output logic [DATA_WIDTH-1:0]              out_data_o,
  output logic [SOURCE_COUNT-1:0]            out_grant_o,
  output logic [(SOURCE_COUNT > 1 ? $clog2(SOURCE_COUNT) : 1)-1:0] out_idx_o,
  input  logic                               out_ready_i
);

  localparam int N         = SOURCE_COUNT;
  localparam int IDX_WIDTH = (N > 1) ? $clog2(N) : 1;

  // Rotate so ptr sits at bit 0, isolate lowest set bit, rotate back.
  function automatic logic [N-1:0] rr_pick(
    input logic [N-1:0]         req,
    input logic [IDX_WIDTH-1:0] ptr
  );
    logic [2*N-1:0] dbl;
    logic [N-1:0]   rot;
    logic [N-1:0]   first;
    dbl   = {req, req} >> ptr;
    rot   = dbl[N-1:0];
    first = rot & (~rot + N'(1));
    dbl   = {first, first} << ptr;
    return dbl[2*N-1:N];
  endfunction

  logic [IDX_WIDTH-1:0]  ptr_q, ptr_d;
  logic                  valid_q, valid_d;
  logic [DATA_WIDTH-1:0] data_q, data_d;
  logic [N-1:0]          grant_q, grant_d;
  logic [IDX_WIDTH-1:0]  idx_q, idx_d;

  logic                  can_load;
  logic [N-1:0]          win_oh;
  logic [IDX_WIDTH-1:0]  win_idx;
  logic [DATA_WIDTH-1:0] win_data;
  logic                  accept;

  assign can_load    = !valid_q || out_ready_i;
  assign win_oh      = rr_pick(req_valid_i, ptr_q);
  assign req_ready_o = can_load ? win_oh : '0;
  assign accept      = |(req_valid_i & req_ready_o);

  always_comb begin
    win_idx = '0;
    for (int j = 0; j < N; j++) begin
      if (win_oh[j]) win_idx = IDX_WIDTH'(j);
    end
  end

  onehot_mux #(
    .SOURCE_COUNT (N),
    .DATA_WIDTH   (DATA_WIDTH)
  ) u_mux (
    .sel_i  (win_oh),
    .data_i (req_data_i),
    .data_o (win_data)
  );

  always_comb begin
    ptr_d   = ptr_q;
    valid_d = valid_q;
    data_d  = data_q;
    grant_d = grant_q;
    idx_d   = idx_q;
    if (accept) begin
      valid_d = 1'b1;
      data_d  = win_data;
      grant_d = win_oh;
      idx_d   = win_idx;
      ptr_d   = (win_idx == IDX_WIDTH'(N-1)) ? '0
              : win_idx + IDX_WIDTH'(1);
    end else if (out_ready_i) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr_q   <= '0;
      valid_q <= 1'b0;
      data_q  <= '0;
      grant_q <= '0;
      idx_q   <= '0;
    end else begin
      ptr_q   <= ptr_d;
      valid_q <= valid_d;
      data_q  <= data_d;
      grant_q <= grant_d;
      idx_q   <= idx_d;
    end
  end

  assign out_valid_o = valid_q;
  assign out_data_o  = data_q;
  assign out_grant_o = grant_q;
  assign out_idx_o   = idx_q;

endmodule

// File: tb/tb_rr_onehot_arbiter.sv
// Directed bench for rr_onehot_arbiter (N=4, 32-bit payloads).
// Adds a random phase checked against a reference ready model and scoreboard.
module tb_rr_onehot_arbiter;

  localparam int N  = 4;
  localparam int DW = 32;
  localparam int IW = 2;

  logic            clk = 1'b0;
  logic            rst;
  logic [N-1:0]    req_valid;
  logic [N*DW-1:0] req_data;
  logic [N-1:0]    req_ready;
  logic            out_valid;
  logic [DW-1:0]   out_data;
  logic [N-1:0]    out_grant;
  logic [IW-1:0]   out_idx;
  logic            out_ready;

  int checks   = 0;
  int failures = 0;

  rr_onehot_arbiter #(
    .SOURCE_COUNT (N),
    .DATA_WIDTH   (DW)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .req_valid_i (req_valid),
    .req_data_i  (req_data),
    .req_ready_o (req_ready),
    .out_valid_o (out_valid),
    .out_data_o  (out_data),
    .out_grant_o (out_grant),
    .out_idx_o   (out_idx),
    .out_ready_i (out_ready)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_slot(input string tag, input logic [DW-1:0] d,
                          input logic [N-1:0] g, input logic [IW-1:0] i);
    chk({tag, "_valid"}, 64'(out_valid), 64'(1));
    chk({tag, "_data"},  64'(out_data),  64'(d));
    chk({tag, "_grant"}, 64'(out_grant), 64'(g));
    chk({tag, "_idx"},   64'(out_idx),   64'(i));
  endtask

  typedef logic [DW-1:0] word_t;
  word_t        sb_q[$];
  word_t        exp_word;
  logic [N-1:0] exp_rdy;
  int           m_ptr;
  bit           m_valid;
  int           k;

  initial begin
    rst       = 1'b1;
    req_valid = '0;
    req_data  = '0;
    out_ready = 1'b0;
    tick();
    tick();
    rst = 1'b0;
    #1;

    chk("rst_valid", 64'(out_valid), 64'(0));
    chk("rst_data",  64'(out_data),  64'(0));
    chk("rst_grant", 64'(out_grant), 64'(0));
    chk("rst_idx",   64'(out_idx),   64'(0));
    for (int c = 0; c < 10; c++) begin
      chk("idle_ready", 64'(req_ready),   64'(0));
      chk("idle_valid", 64'(out_valid),   64'(0));
      chk("idle_ptr",   64'(dut.ptr_q),   64'(0));
      tick();
    end

    // All four valid, payload 0xA0+j, downstream always ready.
    for (int j = 0; j < N; j++) req_data[j*DW +: DW] = DW'(32'hA0 + j);
    req_valid = 4'b1111;
    out_ready = 1'b1;
    #1;
    chk("all_first_ready", 64'(req_ready), 64'(4'b0001));
    for (int c = 0; c < 5; c++) begin
      tick();
      chk_slot("rr", DW'(32'hA0 + (c % N)), N'(1 << (c % N)), IW'(c % N));
    end

    // ptr is 1: lone source 3, then ptr wraps to 0, lone source 1.
    req_valid = 4'b1000;
    #1;
    chk("s3_ready", 64'(req_ready), 64'(4'b1000));
    tick();
    chk_slot("s3", 32'hA3, 4'b1000, 2'd3);
    req_valid = 4'b0010;
    #1;
    chk("s1_ready", 64'(req_ready), 64'(4'b0010));
    tick();
    chk_slot("s1", 32'hA1, 4'b0010, 2'd1);

    // ptr is 2: load source 2, then stall with source 0 waiting.
    req_valid = 4'b0100;
    tick();
    chk_slot("bp_load", 32'hA2, 4'b0100, 2'd2);
    req_valid = 4'b0001;
    out_ready = 1'b0;
    for (int c = 0; c < 3; c++) begin
      #1;
      chk("bp_ready", 64'(req_ready), 64'(0));
      chk_slot("bp_hold", 32'hA2, 4'b0100, 2'd2);
      tick();
    end
    out_ready = 1'b1;
    #1;
    chk("bp_release_ready", 64'(req_ready), 64'(4'b0001));
    tick();
    chk_slot("bp_next", 32'hA0, 4'b0001, 2'd0);

    // Drain; ptr is now 1.
    req_valid = '0;
    tick();
    chk("drain_valid", 64'(out_valid), 64'(0));

    m_ptr   = 1;
    m_valid = 1'b0;
    for (int c = 0; c < 1000; c++) begin
      req_valid = N'($urandom);
      for (int j = 0; j < N; j++) req_data[j*DW +: DW] = $urandom;
      out_ready = (c % 2 == 0) ? 1'b1 : 1'($urandom);
      #1;
      exp_rdy = '0;
      if (!m_valid || out_ready) begin
        for (int o = 0; o < N; o++) begin
          k = (m_ptr + o) % N;
          if (exp_rdy == '0 && req_valid[k]) exp_rdy[k] = 1'b1;
        end
      end
      chk("rnd_ready", 64'(req_ready), 64'(exp_rdy));
      chk("rnd_onehot", 64'($countones(req_ready) <= 1), 64'(1));
      chk("rnd_valid", 64'(out_valid), 64'(m_valid));
      if (out_valid && out_ready) begin
        chk("rnd_sb_nonempty", 64'(sb_q.size() > 0), 64'(1));
        if (sb_q.size() > 0) begin
          exp_word = sb_q.pop_front();
          chk("rnd_sb_data", 64'(out_data), 64'(exp_word));
        end
        m_valid = 1'b0;
      end
      if (exp_rdy != '0) begin
        for (int j = 0; j < N; j++) begin
          if (exp_rdy[j]) begin
            sb_q.push_back(req_data[j*DW +: DW]);
            m_ptr = (j + 1) % N;
          end
        end
        m_valid = 1'b1;
      end
      tick();
    end

    req_valid = '0;
    out_ready = 1'b1;
    #1;
    if (out_valid && sb_q.size() > 0) begin
      exp_word = sb_q.pop_front();
      chk("rnd_drain_data", 64'(out_data), 64'(exp_word));
    end
    tick();
    chk("rnd_sb_empty", 64'(sb_q.size()), 64'(0));
    chk("rnd_drain_valid", 64'(out_valid), 64'(0));

    // Bring ptr to 2 with a held slot, then pulse reset mid-cycle.
    req_valid = 4'b0010;
    for (int j = 0; j < N; j++) req_data[j*DW +: DW] = DW'(32'hA0 + j);
    tick();
    chk_slot("pre_rst", 32'hA1, 4'b0010, 2'd1);
    chk("pre_rst_ptr", 64'(dut.ptr_q), 64'(2));
    out_ready = 1'b0;
    req_valid = 4'b1111;
    #2;
    rst = 1'b1;
    #1;
    chk("async_rst_valid", 64'(out_valid), 64'(0));
    chk("async_rst_grant", 64'(out_grant), 64'(0));
    chk("async_rst_ptr",   64'(dut.ptr_q), 64'(0));
    @(posedge clk);
    #3;
    rst       = 1'b0;
    out_ready = 1'b1;
    #1;
    chk("post_rst_valid", 64'(out_valid), 64'(0));
    chk("post_rst_ready", 64'(req_ready), 64'(4'b0001));
    tick();
    chk_slot("post_rst", 32'hA0, 4'b0001, 2'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
